ex_muldiv: RTL

//   Iterative multiply/divide unit for the EX stage, fed by the ID/EX pipeline register outputs
//   (operand A/B and the decoded mul/div op). It computes MULT/MULTU/DIV/DIVU into the

---
 rtl/mips_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/ex_muldiv.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit and its users.
//   muldiv_op_e    : mul/div operation encoding driven from ID/EX
//   muldiv_state_e : iteration FSM encoding
//   MULDIV_LAT     : cycles busy stays high after a launch, for the hazard unit
package mips_pkg;

    localparam int MULDIV_LAT = 33;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } muldiv_state_e;

    // Bit 0 of the op selects unsigned.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
//   acc_i / acc_o : 2*WIDTH+1 bit working register
//       mul: {carry, partial product high, remaining multiplier bits}
//       div: {partial remainder (WIDTH+1), remaining dividend / quotient bits}
//   opnd_i        : |multiplicand| for mul, |divisor| for div
//   is_div_i      : selects the divide step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  opnd_i,
    input  logic              is_div_i,
    output logic [2*WIDTH:0]  acc_o
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH:0]   diff;

    always_comb begin
        sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
        shl  = {acc_i[2*WIDTH-1:0], 1'b0};
        diff = shl[2*WIDTH:WIDTH] - {1'b0, opnd_i};
        if (is_div_i) begin
            // The shifted remainder can reach WIDTH+1 bits, so compare at that width.
            if (shl[2*WIDTH:WIDTH] >= {1'b0, opnd_i}) begin
                acc_o = {diff, shl[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = shl;
            end
        end else begin
            acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
//   clk_i, reset_i (async, active-high)
//   start_i, op_i, op_a_i, op_b_i : launch from ID/EX (sampled in IDLE only)
//   abort_i                       : flush, returns to IDLE without touching HI/LO
//   mthi_i, mtlo_i, mt_data_i     : MTHI/MTLO writes (IDLE only, start has priority)
//   hi_o, lo_o                    : HI/LO registers
//   busy_o                        : op in flight
//   done_o                        : one-cycle pulse after HI/LO are written by an op
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [WIDTH-1:0]  op_a_i,
    input  logic [WIDTH-1:0]  op_b_i,
    input  logic              abort_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    input  logic [WIDTH-1:0]  mt_data_i,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o,
    output logic              busy_o,
    output logic              done_o
);

    muldiv_state_e     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*WIDTH:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  a_raw_q;
    logic              is_div_q;
    logic              neg_q;       // negate product (mul) or quotient (div)
    logic              rem_neg_q;   // remainder follows the dividend's sign
    logic              div_zero_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              done_q;

    logic              sgn, a_neg, b_neg;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  quot, rem;
    logic [WIDTH-1:0]  hi_d, lo_d;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_d)
    );

    always_comb begin
        sgn   = op_is_signed(op_i);
        a_neg = sgn & op_a_i[WIDTH-1];
        b_neg = sgn & op_b_i[WIDTH-1];
        a_abs = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        b_abs = b_neg ? (~op_b_i + 1'b1) : op_b_i;
    end

    always_comb begin
        prod = neg_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
        quot = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end else if (div_zero_q) begin
            // Divide by zero reports the raw dividend, not its magnitude.
            hi_d = a_raw_q;
            lo_d = {WIDTH{1'b1}};
        end else begin
            hi_d = rem;
            lo_d = quot;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            is_div_q   <= op_i[1];
                            a_raw_q    <= op_a_i;
                            div_zero_q <= (op_b_i == '0);
                            neg_q      <= a_neg ^ b_neg;
                            rem_neg_q  <= a_neg;
                            cnt_q      <= '0;
                            if (op_i[1]) begin
                                acc_q  <= {{(WIDTH+1){1'b0}}, a_abs};
                                opnd_q <= b_abs;
                            end else begin
                                acc_q  <= {{(WIDTH+1){1'b0}}, b_abs};
                                opnd_q <= a_abs;
                            end
                            state_q <= ITER;
                        end else begin
                            if (mthi_i) hi_q <= mt_data_i;
                            if (mtlo_i) lo_q <= mt_data_i;
                        end
                    end
                    ITER: begin
                        acc_q <= acc_d;
                        if (cnt_q == CNT_W'(WIDTH-1)) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    FIX: begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule
